// File: rtl/dla_pkg.sv
// Shared constants and types for the logic-analyzer capture buffer.
package dla_pkg;
  localparam int unsigned DLA_DEPTH  = 1024;
  localparam int unsigned DLA_ADDR_W = 10;
  localparam int unsigned DLA_DATA_W = 8;

  typedef logic [DLA_DATA_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_READY   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_FETCH   = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;
endpackage

// File: rtl/sample_buffer_ctrl_if.sv
// Host readout stream: sample data with valid/ready handshake and end-of-stream marker.
interface sample_buffer_ctrl_if
  import dla_pkg::*;
#(
  parameter int unsigned DATA_W = DLA_DATA_W
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              in_ready;

  modport master (output out_data, output out_valid, output out_last, input in_ready);
  modport slave  (input out_data, input out_valid, input out_last, output in_ready);
endinterface

// File: rtl/circ_ptr.sv
// Modulo-DEPTH ring pointer with synchronous clear, load and increment; wrap is sticky until cleared or loaded.
module circ_ptr
  import dla_pkg::*;
#(
  parameter int unsigned ADDR_W = DLA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);
  logic [ADDR_W-1:0] ptr_r;
  logic              wrap_r;

  // Pointer and wrap flag; clear beats load beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r  <= {ADDR_W{1'b0}};
      wrap_r <= 1'b0;
    end else if (clr) begin
      ptr_r  <= {ADDR_W{1'b0}};
      wrap_r <= 1'b0;
    end else if (load) begin
      ptr_r  <= load_val;
      wrap_r <= 1'b0;
    end else if (inc) begin
      ptr_r <= ptr_r + ADDR_W'(1);
      if (ptr_r == {ADDR_W{1'b1}}) begin
        wrap_r <= 1'b1;
      end
    end
  end

  assign ptr  = ptr_r;
  assign wrap = wrap_r;
endmodule

// File: rtl/sample_buffer_ctrl.sv
// Capture-RAM sequencer: circular writes during capture, then oldest-first readout to the host.
module sample_buffer_ctrl
  import dla_pkg::*;
#(
  parameter int unsigned DEPTH  = DLA_DEPTH,
  parameter int unsigned ADDR_W = DLA_ADDR_W,
  parameter int unsigned DATA_W = DLA_DATA_W
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  input  logic                 in_ce,
  input  logic                 in_done,
  input  logic                 in_trig,
  input  logic                 in_abort,
  input  logic [DATA_W-1:0]    in_sample,
  output logic                 out_wr_en,
  output logic [ADDR_W-1:0]    out_wr_addr,
  output logic [DATA_W-1:0]    out_wr_data,
  output logic                 out_rd_en,
  output logic [ADDR_W-1:0]    out_rd_addr,
  input  logic [DATA_W-1:0]    in_rd_data,
  input  logic                 in_read_req,
  sample_buffer_ctrl_if.master host,
  output logic [ADDR_W:0]      out_count,
  output logic [ADDR_W-1:0]    out_trig_offset,
  output logic                 out_trig_seen,
  output logic [2:0]           out_state
);
  state_e            state_r, nxt_state_s;
  logic [ADDR_W-1:0] wr_ptr_s, rd_ptr_s, start_s, start_r;
  logic [ADDR_W-1:0] trig_addr_r, trig_offset_s, trig_offset_r, wr_addr_r;
  logic [ADDR_W:0]   count_s, count_r, remaining_r;
  logic [DATA_W-1:0] wr_data_r, data_r;
  logic              wr_wrap_s, rd_wrap_unused_s;
  logic              wr_fire_s, to_ready_s, rd_load_s, accept_s;
  logic              trig_seen_r, wr_en_r, rd_en_r, valid_r, last_r;

  circ_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk(in_clk), .rst(in_reset), .clr(in_abort), .load(1'b0),
    .load_val({ADDR_W{1'b0}}), .inc(wr_fire_s), .ptr(wr_ptr_s), .wrap(wr_wrap_s)
  );

  circ_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk(in_clk), .rst(in_reset), .clr(in_abort), .load(rd_load_s),
    .load_val(start_r), .inc(accept_s), .ptr(rd_ptr_s), .wrap(rd_wrap_unused_s)
  );

  // Capture summary: once wrapped the oldest sample sits at the write pointer.
  always_comb begin
    start_s       = {ADDR_W{1'b0}};
    count_s       = {1'b0, wr_ptr_s};
    trig_offset_s = {ADDR_W{1'b0}};
    if (wr_wrap_s) begin
      start_s = wr_ptr_s;
      count_s = (ADDR_W+1)'(DEPTH);
    end else begin
      start_s = {ADDR_W{1'b0}};
      count_s = {1'b0, wr_ptr_s};
    end
    if (trig_seen_r) begin
      trig_offset_s = trig_addr_r - start_s;
    end else begin
      trig_offset_s = {ADDR_W{1'b0}};
    end
  end

  // Next-state and per-cycle strobes; abort wins, then done over capture enable.
  always_comb begin
    nxt_state_s = state_r;
    wr_fire_s   = 1'b0;
    to_ready_s  = 1'b0;
    rd_load_s   = 1'b0;
    accept_s    = 1'b0;
    if (in_abort) begin
      nxt_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_CAPTURE: begin
          if (in_done) begin
            nxt_state_s = ST_READY;
            to_ready_s  = 1'b1;
          end else if (in_ce) begin
            nxt_state_s = ST_CAPTURE;
            wr_fire_s   = 1'b1;
          end else begin
            nxt_state_s = state_r;
          end
        end
        ST_READY: begin
          if (in_read_req && (count_r != {(ADDR_W+1){1'b0}})) begin
            nxt_state_s = ST_ISSUE;
            rd_load_s   = 1'b1;
          end else begin
            nxt_state_s = ST_READY;
          end
        end
        ST_ISSUE: nxt_state_s = ST_FETCH;
        ST_FETCH: nxt_state_s = ST_HOLD;
        ST_HOLD: begin
          if (host.in_ready) begin
            accept_s    = 1'b1;
            nxt_state_s = (remaining_r == (ADDR_W+1)'(1)) ? ST_READY : ST_ISSUE;
          end else begin
            nxt_state_s = ST_HOLD;
          end
        end
        default: nxt_state_s = ST_IDLE;
      endcase
    end
  end

  // State register plus capture side: write port, first-trigger latch, capture summary.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_r       <= ST_IDLE;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= {DATA_W{1'b0}};
      trig_seen_r   <= 1'b0;
      trig_addr_r   <= {ADDR_W{1'b0}};
      start_r       <= {ADDR_W{1'b0}};
      count_r       <= {(ADDR_W+1){1'b0}};
      trig_offset_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= nxt_state_s;
      wr_en_r <= wr_fire_s;
      if (wr_fire_s) begin
        wr_addr_r <= wr_ptr_s;
        wr_data_r <= in_sample;
      end
      if (in_abort) begin
        trig_seen_r   <= 1'b0;
        trig_addr_r   <= {ADDR_W{1'b0}};
        start_r       <= {ADDR_W{1'b0}};
        count_r       <= {(ADDR_W+1){1'b0}};
        trig_offset_r <= {ADDR_W{1'b0}};
      end else if (to_ready_s) begin
        start_r       <= start_s;
        count_r       <= count_s;
        trig_offset_r <= trig_offset_s;
      end else if (wr_fire_s && in_trig && !trig_seen_r) begin
        trig_seen_r <= 1'b1;
        trig_addr_r <= wr_ptr_s;
      end
    end
  end

  // Readout side: RAM read strobe, remaining count and the held host sample.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      rd_en_r     <= 1'b0;
      remaining_r <= {(ADDR_W+1){1'b0}};
      data_r      <= {DATA_W{1'b0}};
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
    end else begin
      rd_en_r <= (nxt_state_s == ST_ISSUE);
      if (rd_load_s) begin
        remaining_r <= count_r;
      end else if (accept_s) begin
        remaining_r <= remaining_r - (ADDR_W+1)'(1);
      end
      if (in_abort || accept_s) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end else if (state_r == ST_FETCH) begin
        data_r  <= in_rd_data;
        valid_r <= 1'b1;
        last_r  <= (remaining_r == (ADDR_W+1)'(1));
      end
    end
  end

  assign out_wr_en       = wr_en_r;
  assign out_wr_addr     = wr_addr_r;
  assign out_wr_data     = wr_data_r;
  assign out_rd_en       = rd_en_r;
  assign out_rd_addr     = rd_ptr_s;
  assign host.out_data   = data_r;
  assign host.out_valid  = valid_r;
  assign host.out_last   = last_r;
  assign out_count       = count_r;
  assign out_trig_offset = trig_offset_r;
  assign out_trig_seen   = trig_seen_r;
  assign out_state       = state_r;
endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// Directed bench for sample_buffer_ctrl: capture table plus abort, empty-buffer and reset sequences.
module tb_sample_buffer_ctrl;
  import dla_pkg::*;

  logic       in_clk = 1'b0;
  logic       in_reset, in_ce, in_done, in_trig, in_abort, in_read_req;
  logic [7:0] in_sample, in_rd_data;
  logic       out_wr_en, out_rd_en, out_trig_seen;
  logic [9:0] out_wr_addr, out_rd_addr, out_trig_offset;
  logic [7:0] out_wr_data;
  logic [10:0] out_count;
  logic [2:0] out_state;

  always #5 in_clk = ~in_clk;

  sample_buffer_ctrl_if host_if ();

  sample_buffer_ctrl dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_ce(in_ce), .in_done(in_done),
    .in_trig(in_trig), .in_abort(in_abort), .in_sample(in_sample),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .in_rd_data(in_rd_data),
    .in_read_req(in_read_req), .host(host_if), .out_count(out_count),
    .out_trig_offset(out_trig_offset), .out_trig_seen(out_trig_seen), .out_state(out_state)
  );

  // Capture RAM model with one-cycle read latency.
  logic [7:0] mem [0:1023];
  always @(posedge in_clk) begin
    if (out_wr_en) mem[out_wr_addr] <= out_wr_data;
    if (out_rd_en) in_rd_data <= mem[out_rd_addr];
  end

  int cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  logic [64:0] all_outs;
  assign all_outs = {out_wr_en, out_wr_addr, out_wr_data, out_rd_en, out_rd_addr,
                     host_if.out_data, host_if.out_valid, host_if.out_last,
                     out_count, out_trig_offset, out_trig_seen, out_state};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int n; int trig_at; int pause_at; int seed; bit toggle; bit done_ce;
    int exp_count; int exp_offset; bit exp_seen; int exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic abort_to_idle();
    in_abort = 1'b1;
    @(negedge in_clk);
    in_abort = 1'b0;
  endtask

  task automatic capture(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      if (i == v.pause_at) begin
        in_ce = 1'b0; in_trig = 1'b1;
        repeat (3) @(negedge in_clk);
      end
      in_ce     = 1'b1;
      in_sample = 8'(i + v.seed);
      in_trig   = (v.trig_at >= 0) && (i >= v.trig_at);
      @(negedge in_clk);
    end
    in_ce = v.done_ce; in_trig = v.done_ce; in_done = 1'b1;
    @(negedge in_clk);
    in_ce = 1'b0; in_trig = 1'b0; in_done = 1'b0;
  endtask

  task automatic readout(input int n, input int n_acc, input int first, input int seed,
                         input bit toggle, output int bad, output int got,
                         output int unstable, output int cycles);
    int c0;
    int guard;
    sample_t d0;
    logic l0;
    bad = 0; got = 0; unstable = 0;
    in_ready_set(1'b0);
    in_read_req = 1'b1;
    @(negedge in_clk);
    in_read_req = 1'b0;
    c0 = cyc;
    for (int k = 0; k < n_acc; k++) begin
      guard = 0;
      while (host_if.out_valid !== 1'b1 && guard < 20) begin
        @(negedge in_clk);
        guard++;
      end
      if (host_if.out_valid !== 1'b1) begin
        bad++;
        break;
      end
      d0 = host_if.out_data;
      l0 = host_if.out_last;
      if (d0 !== 8'(first + k + seed) || l0 !== (k == n - 1)) bad++;
      if (toggle) begin
        repeat (2) begin
          @(negedge in_clk);
          if (host_if.out_valid !== 1'b1 || host_if.out_data !== d0 || host_if.out_last !== l0)
            unstable++;
        end
      end
      in_ready_set(1'b1);
      @(negedge in_clk);
      in_ready_set(1'b0);
      got++;
      if (host_if.out_valid !== 1'b0) bad++;
    end
    cycles = cyc - c0;
  endtask

  task automatic in_ready_set(input logic r);
    host_if.in_ready = r;
  endtask

  initial begin
    int bad, got, unstable, cycles, guard;
    int any_valid, any_rd, any_wr, not_ready;
    vec_t t5;

    //          n     trig  pause seed tog dce  count off   seen first
    vecs[0] = '{300,  100,  -1,   0,   0,  1,   300,  100,  1,   0};
    vecs[1] = '{1500, 1200, -1,   5,   0,  0,   1024, 724,  1,   476};
    vecs[2] = '{1024, 0,    -1,   9,   0,  0,   1024, 0,    1,   0};
    vecs[3] = '{1023, -1,   500,  17,  0,  0,   1023, 0,    0,   0};
    vecs[4] = '{1,    0,    -1,   77,  0,  1,   1,    0,    1,   0};
    vecs[5] = '{1025, 1024, -1,   33,  0,  0,   1024, 1023, 1,   1};
    vecs[6] = '{40,   39,   -1,   101, 1,  0,   40,   39,   1,   0};

    in_reset = 1'b1; in_ce = 1'b0; in_done = 1'b0; in_trig = 1'b0; in_abort = 1'b0;
    in_read_req = 1'b0; in_sample = 8'd0; in_ready_set(1'b0);
    repeat (3) @(negedge in_clk);
    check("reset_outs_zero", 64'(all_outs === 65'd0), 64'd1);
    in_reset = 1'b0;
    @(negedge in_clk);
    check("post_reset_state", 64'(out_state), 64'd0);

    for (int v = 0; v < 7; v++) begin
      abort_to_idle();
      check($sformatf("v%0d_idle", v), 64'(out_state), 64'd0);
      capture(vecs[v]);
      check($sformatf("v%0d_ready", v), 64'(out_state), 64'd2);
      check($sformatf("v%0d_count", v), 64'(out_count), 64'(vecs[v].exp_count));
      check($sformatf("v%0d_offset", v), 64'(out_trig_offset), 64'(vecs[v].exp_offset));
      check($sformatf("v%0d_seen", v), 64'(out_trig_seen), 64'(vecs[v].exp_seen));
      readout(vecs[v].exp_count, vecs[v].exp_count, vecs[v].exp_first, vecs[v].seed,
              vecs[v].toggle, bad, got, unstable, cycles);
      check($sformatf("v%0d_stream_errs", v), 64'(bad), 64'd0);
      check($sformatf("v%0d_received", v), 64'(got), 64'(vecs[v].exp_count));
      check($sformatf("v%0d_unstable", v), 64'(unstable), 64'd0);
      check($sformatf("v%0d_cycles", v), 64'(cycles),
            64'((vecs[v].toggle ? 5 : 3) * vecs[v].exp_count));
      check($sformatf("v%0d_back_ready", v), 64'(out_state), 64'd2);
      check($sformatf("v%0d_count_kept", v), 64'(out_count), 64'(vecs[v].exp_count));
    end

    // Empty buffer: done with no samples, read request must not start a stream; ce ignored.
    abort_to_idle();
    in_done = 1'b1;
    @(negedge in_clk);
    in_done = 1'b0;
    check("empty_state", 64'(out_state), 64'd2);
    check("empty_count", 64'(out_count), 64'd0);
    any_valid = 0; any_rd = 0; any_wr = 0; not_ready = 0;
    in_read_req = 1'b1; in_ce = 1'b1; in_sample = 8'h5A;
    repeat (10) begin
      @(negedge in_clk);
      if (host_if.out_valid !== 1'b0) any_valid++;
      if (out_rd_en !== 1'b0) any_rd++;
      if (out_wr_en !== 1'b0) any_wr++;
      if (out_state !== 3'd2) not_ready++;
    end
    in_read_req = 1'b0; in_ce = 1'b0;
    check("empty_valid", 64'(any_valid), 64'd0);
    check("empty_rd_en", 64'(any_rd), 64'd0);
    check("ready_ce_ignored", 64'(any_wr), 64'd0);
    check("empty_stays_ready", 64'(not_ready), 64'd0);

    // Abort while holding sample 50.
    abort_to_idle();
    t5 = '{100, 10, -1, 3, 0, 0, 100, 10, 1, 0};
    capture(t5);
    check("abort_pre_seen", 64'(out_trig_seen), 64'd1);
    readout(100, 50, 0, 3, 1'b0, bad, got, unstable, cycles);
    check("abort_pre_stream", 64'(bad), 64'd0);
    guard = 0;
    while (host_if.out_valid !== 1'b1 && guard < 20) begin
      @(negedge in_clk);
      guard++;
    end
    check("abort_hold_data", 64'(host_if.out_data), 64'(8'(50 + 3)));
    in_abort = 1'b1;
    @(negedge in_clk);
    in_abort = 1'b0;
    check("abort_valid", 64'(host_if.out_valid), 64'd0);
    check("abort_state", 64'(out_state), 64'd0);
    check("abort_rd_en", 64'(out_rd_en), 64'd0);
    in_ce = 1'b1; in_sample = 8'hA5;
    @(negedge in_clk);
    in_ce = 1'b0;
    check("recapture_wr_en", 64'(out_wr_en), 64'd1);
    check("recapture_addr", 64'(out_wr_addr), 64'd0);
    check("recapture_data", 64'(out_wr_data), 64'hA5);
    check("recapture_seen", 64'(out_trig_seen), 64'd0);
    check("recapture_state", 64'(out_state), 64'd1);

    // Asynchronous reset between clock edges in the middle of a capture.
    for (int i = 0; i < 10; i++) begin
      in_ce = 1'b1; in_sample = 8'(i);
      @(negedge in_clk);
    end
    check("pre_reset_wr_en", 64'(out_wr_en), 64'd1);
    #2;
    in_reset = 1'b1;
    #1;
    check("async_reset_outs", 64'(all_outs === 65'd0), 64'd1);
    in_ce = 1'b0;
    @(negedge in_clk);
    in_reset = 1'b0;
    any_wr = 0;
    repeat (3) begin
      @(negedge in_clk);
      if (out_wr_en !== 1'b0) any_wr++;
    end
    check("post_reset_no_write", 64'(any_wr), 64'd0);
    check("post_reset_idle", 64'(out_state), 64'd0);
    in_ce = 1'b1; in_sample = 8'h3C;
    @(negedge in_clk);
    in_ce = 1'b0;
    check("post_reset_first_addr", 64'(out_wr_addr), 64'd0);
    check("post_reset_first_wr", 64'(out_wr_en), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_buffer_ctrl.md
Name: sample_buffer_ctrl

Overview:
Address sequencer and readout controller for the 1024-deep, 8-bit capture RAM of the logic analyzer. During capture it turns the capture state machine's clock-enable into circular RAM writes and records where the trigger landed. After capture completes it streams the buffer to the host interface oldest-sample-first over a valid/ready handshake, and reports sample count and trigger offset.

Parameters:
DEPTH, 1024, capture RAM depth in samples (power of two)
ADDR_W, 10, log2(DEPTH)
DATA_W, 8, sample width

Ports:
in_clk  input  1  system clock
in_reset  input  1  asynchronous, active-high reset
in_ce  input  1  capture enable from capture state machine; one sample per cycle while high
in_done  input  1  capture-complete level from capture state machine
in_trig  input  1  trigger-qualified pulse/level
in_abort  input  1  host abort (idle request); synchronous
in_sample  input  DATA_W  probe sample to store
out_wr_en  output  1  RAM write enable
out_wr_addr  output  ADDR_W  RAM write address
out_wr_data  output  DATA_W  RAM write data
out_rd_en  output  1  RAM read enable (RAM read latency is exactly 1 cycle)
out_rd_addr  output  ADDR_W  RAM read address
in_rd_data  input  DATA_W  RAM read data
in_read_req  input  1  host request to start readout
out_data  output  DATA_W  readout sample to host
out_valid  output  1  out_data valid
in_ready  input  1  host accepts out_data
out_last  output  1  with out_valid: final sample of stream
out_count  output  ADDR_W+1  samples held (0..DEPTH), valid in READY/READ states
out_trig_offset  output  ADDR_W  stream index of first triggered sample
out_trig_seen  output  1  trigger recorded this capture
out_state  output  3  current state, for debug/status

Behaviour:
- Reset (async, in_reset=1): state IDLE; all outputs 0; write pointer, wrap flag, trig address, remaining count cleared.
- States: IDLE=0, CAPTURE=1, READY=2, ISSUE=3, FETCH=4, HOLD=5.
- IDLE: in_ce=1 -> CAPTURE. The same cycle's sample is written. Clear wr_ptr, wrap, trig_seen on entry.
- Write path: every cycle in_ce=1 in IDLE/CAPTURE, register out_wr_en=1, out_wr_addr=wr_ptr, out_wr_data=in_sample. This gives one cycle of latency. wr_ptr increments mod DEPTH. When wr_ptr goes DEPTH-1 -> 0, wrap=1 (sticky).
- Trigger: the first cycle with in_trig=1 and in_ce=1 latches trig_addr=wr_ptr and sets out_trig_seen. Later triggers are ignored until the next capture.
- CAPTURE: in_done=1 -> READY. in_done takes priority over in_ce in the same cycle, and no write occurs that cycle. in_ce low without in_done: stay, no write (pre-trigger pause).
- Entering READY:
  - wrap=1: start=wr_ptr, count=DEPTH.
  - wrap=0: start=0, count=wr_ptr.
  - out_trig_offset=(trig_addr-start) mod DEPTH, or 0 if no trigger seen.
- READY: in_read_req=1 and count>0 -> ISSUE with rd_ptr=start, remaining=count. If count=0, stay in READY and keep out_valid low.
- ISSUE: out_rd_en=1, out_rd_addr=rd_ptr for one cycle -> FETCH.
- FETCH: capture in_rd_data into out_data, assert out_valid, set out_last=(remaining==1) -> HOLD.
- HOLD: hold out_data, out_valid and out_last stable until in_ready=1.
  - On acceptance: drop out_valid, rd_ptr+1 mod DEPTH, remaining-1.
  - remaining was 1 -> READY, with count unchanged so the host can re-read. Otherwise -> ISSUE.
- Throughput: 1 sample per 3 cycles with in_ready held high.
- in_abort=1 in any state -> IDLE next cycle. out_valid, out_rd_en and out_wr_en are deasserted and no write occurs. Abort has priority over every other input.
- in_ce=1 in READY or a readout state: ignored, no write. A new capture requires abort or reset first.
- Reset mid-readout: outputs drop asynchronously. No partial handshake is required.

Decomposition:
- Shared package dla_pkg: state encoding constants (IDLE..HOLD), DEPTH/ADDR_W/DATA_W defaults, sample type width.
- One natural sub-module: circ_ptr (mod-DEPTH pointer with increment, load and wrap flag), used twice, for wr_ptr and rd_ptr.

Test Plan:
1. Reset, in_ce=1 for 300 cycles with samples 0..299 (mod 256), in_trig at cycle 100, then in_done -> out_count=300, out_trig_offset=100; readout yields 300 samples in order, out_last on the 300th.
2. in_ce=1 for 1500 cycles, trig at cycle 1200, then in_done -> out_count=1024, stream starts at sample index 476 (addr 476), out_trig_offset=724.
3. Readout with in_ready toggled 1 cycle on / 2 off -> out_data and out_valid stable while not accepted; no sample lost or duplicated.
4. in_done with no prior in_ce (count 0), in_read_req=1 -> stays READY, out_valid never asserted.
5. in_abort during HOLD at sample 50 -> out_valid=0 next cycle, state IDLE. A new capture restarts at wr_addr 0, and out_trig_seen is cleared.
6. Async in_reset pulse mid-CAPTURE between clock edges -> all outputs 0 immediately, out_state=0; no write after release until in_ce.
